// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle R/I-type datapath with a retired-instruction counter.
// Define ILLEGAL_TRAP_EN to halt on unknown opcodes (sticky illegal_o) instead of skipping them.
module multicycle_control #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [6:0]       Op_i,
   output logic             IRWrite_o,
   output logic             PCWrite_o,
   output logic [1:0]       ALUOp_o,
   output logic             ALUSrc_o,
   output logic             RegWrite_o,
   output logic [2:0]       state_o,
   output logic             busy_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] retired_o
);

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StFetch     = 3'd1,
      StDecode    = 3'd2,
      StExecute   = 3'd3,
      StWriteback = 3'd4,
      StHalt      = 3'd5
   } state_e;

   localparam logic [6:0] OpR    = 7'b0110011;
   localparam logic [6:0] OpI    = 7'b0010011;
   localparam logic [6:0] OpHalt = 7'b0000000;

   state_e           state_q, state_d;
   logic [6:0]       op_q, op_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic op_q_is_r, op_q_is_i, op_q_legal;
   logic op_in_legal;

   assign op_q_is_r   = (op_q == OpR);
   assign op_q_is_i   = (op_q == OpI);
   assign op_q_legal  = op_q_is_r | op_q_is_i;
   assign op_in_legal = (Op_i == OpR) | (Op_i == OpI);

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
`endif

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      retired_d = retired_q;
`ifdef ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif
      case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StFetch;
            end
         end
         StFetch: begin
            state_d = StDecode;
         end
         StDecode: begin
            op_d = Op_i;
            if (op_in_legal) begin
               state_d = StExecute;
            end else if (Op_i == OpHalt) begin
               state_d = StHalt;
            end else begin
`ifdef ILLEGAL_TRAP_EN
               state_d   = StHalt;
               illegal_d = 1'b1;
`else
               // Unknown opcode retires nothing but still advances the PC.
               state_d = StWriteback;
`endif
            end
         end
         StExecute: begin
            state_d = StWriteback;
         end
         StWriteback: begin
            if (op_q_legal) begin
               retired_d = retired_q + CNT_W'(1);
            end
            state_d = start_i ? StFetch : StIdle;
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         op_q      <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         retired_q <= retired_d;
      end
   end

`ifdef ILLEGAL_TRAP_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= illegal_d;
      end
   end

   assign illegal_o = illegal_q;
`else
   assign illegal_o = 1'b0;
`endif

   // Outputs decode only registered state and op_q.
   always_comb begin
      IRWrite_o  = 1'b0;
      PCWrite_o  = 1'b0;
      ALUOp_o    = 2'b00;
      ALUSrc_o   = 1'b0;
      RegWrite_o = 1'b0;
      busy_o     = 1'b1;
      case (state_q)
         StIdle, StHalt: begin
            busy_o = 1'b0;
         end
         StFetch: begin
            IRWrite_o = 1'b1;
         end
         StExecute, StWriteback: begin
            if (op_q_is_r) begin
               ALUOp_o = 2'b10;
            end else if (op_q_is_i) begin
               ALUOp_o  = 2'b11;
               ALUSrc_o = 1'b1;
            end
            if (state_q == StWriteback) begin
               PCWrite_o  = 1'b1;
               RegWrite_o = op_q_legal;
            end
         end
         default: begin
         end
      endcase
   end

   assign state_o   = state_q;
   assign retired_o = retired_q;

endmodule
